// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the priority encoder family.
//   - MODE encodings selecting the search policy of rr_pick.
//   - mode_legal(): elaboration-time legality test for a MODE value.
//   - multi_hot(): true when a vector has more than one bit set.
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int MODE_LSB = 0;  // fixed priority, lowest index wins
  localparam int MODE_MSB = 1;  // fixed priority, highest index wins
  localparam int MODE_RR  = 2;  // round-robin, starting after the last grant

  function automatic bit mode_legal(input int mode);
    return (mode == MODE_LSB) || (mode == MODE_MSB) || (mode == MODE_RR);
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were
  // set, which avoids building a full popcount adder tree.
  function automatic logic multi_hot(input logic [31:0] vec);
    return |(vec & (vec - 32'd1));
  endfunction

endpackage : enc_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational request search.
// Parameters:
//   N     number of requests (>= 2)
//   MODE  MODE_LSB / MODE_MSB / MODE_RR (see enc_pkg)
// Ports:
//   req    in   N  request vector
//   ptr    in   W  last granted index (used by MODE_RR only)
//   idx    out  W  selected index (0 when nothing is requested)
//   found  out  1  at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_LSB,
  localparam int W    = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    // NOTE: every output gets a default before the search, otherwise the paths
    // where no bit matches would hold the old value and infer a latch.
    idx   = '0;
    found = |req;
    case (MODE)
      MODE_LSB: begin
        // Descending scan: the last match written is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
          if (req[i]) idx = W'(i);
        end
      end
      MODE_MSB: begin
        // Ascending scan: the last match written is the highest set bit.
        for (int i = 0; i < N; i++) begin
          if (req[i]) idx = W'(i);
        end
      end
      default: begin
        // Round-robin: walk offsets ptr+N down to ptr+1 so the final match is
        // the nearest set bit above ptr, wrapping modulo N (N need not be a
        // power of two, so the wrap is an explicit modulo).
        for (int off = N; off >= 1; off--) begin
          if (req[(int'(ptr) + off) % N]) idx = W'((int'(ptr) + off) % N);
        end
      end
    endcase
  end

endmodule : rr_pick

// File: rtl/priority_encoder_rr.sv
// -----------------------------------------------------------------------------
// priority_encoder_rr
// Registered priority encoder with a valid/ready output handshake.
// A request vector is captured when sel=1, req_in is non-zero and the output
// register is free (empty or being consumed this cycle). The encoded index and
// a multi-request flag appear one cycle later and hold until consumed.
// Parameters:
//   N     number of request inputs (>= 2)
//   MODE  0 = LSB-first, 1 = MSB-first, 2 = round-robin
// Ports:
//   clk         in   1  clock, rising edge
//   rst         in   1  synchronous active-high reset
//   sel         in   1  capture enable
//   req_in      in   N  request vector
//   out_ready   in   1  downstream consumes the result this cycle
//   binary_out  out  W  registered index of the selected request
//   out_valid   out  1  binary_out holds an unconsumed result
//   multi       out  1  captured vector had more than one bit set
// -----------------------------------------------------------------------------
module priority_encoder_rr
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_LSB,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic [W-1:0] binary_out,
  output logic         out_valid,
  output logic         multi
);

  // Reject unsupported configurations while elaborating.
  if (!mode_legal(MODE)) begin : g_bad_mode
    $error("priority_encoder_rr: illegal MODE %0d", MODE);
  end
  if (N < 2) begin : g_bad_n
    $error("priority_encoder_rr: N must be at least 2, got %0d", N);
  end

  logic [W-1:0] r_idx;
  logic         r_valid;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic [W-1:0] w_pick_idx;
  logic         w_found;
  logic         w_cap;
  logic         w_multi;

  rr_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .req   (req_in),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_found)
  );

  // The output register may be reloaded when empty, or when its current
  // contents are leaving this same cycle (back-to-back, no bubble).
  assign w_cap   = sel && w_found && (!r_valid || out_ready);
  assign w_multi = multi_hot(32'(req_in));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_ptr   <= W'(N - 1);  // first round-robin search starts at bit 0
    end else if (w_cap) begin
      r_idx   <= w_pick_idx;
      r_valid <= 1'b1;
      r_multi <= w_multi;
      r_ptr   <= w_pick_idx;
    end else if (out_ready) begin
      // Consumed with nothing new to load: data and flag keep last values.
      r_valid <= 1'b0;
    end
  end

  assign binary_out = r_idx;
  assign out_valid  = r_valid;
  assign multi      = r_multi;

endmodule : priority_encoder_rr

// File: tb/tb_priority_encoder_rr.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_rr
// Directed vectors applied in parallel to four configurations:
//   u_lsb (N=8, MODE 0), u_msb (N=8, MODE 1), u_rr (N=8, MODE 2),
//   u_rr5 (N=5, MODE 2, driven from req_in[4:0]).
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] req_in;
  logic       out_ready;

  logic [2:0] lsb_out, msb_out, rr_out, rr5_out;
  logic       lsb_vld, msb_vld, rr_vld, rr5_vld;
  logic       lsb_mul, msb_mul, rr_mul, rr5_mul;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8), .MODE(0)) u_lsb (
    .clk(clk), .rst(rst), .sel(sel), .req_in(req_in), .out_ready(out_ready),
    .binary_out(lsb_out), .out_valid(lsb_vld), .multi(lsb_mul));

  priority_encoder_rr #(.N(8), .MODE(1)) u_msb (
    .clk(clk), .rst(rst), .sel(sel), .req_in(req_in), .out_ready(out_ready),
    .binary_out(msb_out), .out_valid(msb_vld), .multi(msb_mul));

  priority_encoder_rr #(.N(8), .MODE(2)) u_rr (
    .clk(clk), .rst(rst), .sel(sel), .req_in(req_in), .out_ready(out_ready),
    .binary_out(rr_out), .out_valid(rr_vld), .multi(rr_mul));

  priority_encoder_rr #(.N(5), .MODE(2)) u_rr5 (
    .clk(clk), .rst(rst), .sel(sel), .req_in(req_in[4:0]), .out_ready(out_ready),
    .binary_out(rr5_out), .out_valid(rr5_vld), .multi(rr5_mul));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic [7:0] q,
                       input logic rdy);
    rst       = r;
    sel       = s;
    req_in    = q;
    out_ready = rdy;
  endtask

  // Expected round-robin sequences for a held 8'h11 / 5'b10001 after reset.
  int rr8_seq [4] = '{0, 4, 0, 4};
  int rr5_seq [4] = '{0, 4, 0, 4};

  initial begin
    // ---------------- reset state ----------------
    drive(1'b1, 1'b1, 8'hFF, 1'b1);
    step();
    step();
    check("rst_lsb_out", int'(lsb_out), 0);
    check("rst_lsb_vld", int'(lsb_vld), 0);
    check("rst_lsb_mul", int'(lsb_mul), 0);
    check("rst_rr_vld",  int'(rr_vld),  0);
    check("rst_rr5_vld", int'(rr5_vld), 0);

    // ---------------- 8'h28 in every mode ----------------
    drive(1'b0, 1'b1, 8'h28, 1'b1);
    step();
    check("lsb_28_out", int'(lsb_out), 3);
    check("lsb_28_vld", int'(lsb_vld), 1);
    check("lsb_28_mul", int'(lsb_mul), 1);
    check("msb_28_out", int'(msb_out), 5);
    check("msb_28_mul", int'(msb_mul), 1);
    check("rr_28_out",  int'(rr_out),  3);   // ptr=7 -> search from bit 0
    check("rr5_08_out", int'(rr5_out), 3);   // req[4:0]=01000, single bit
    check("rr5_08_mul", int'(rr5_mul), 0);

    // ---------------- 8'h80: single bit, back-to-back ----------------
    drive(1'b0, 1'b1, 8'h80, 1'b1);
    step();
    check("msb_80_out", int'(msb_out), 7);
    check("msb_80_mul", int'(msb_mul), 0);
    check("lsb_80_out", int'(lsb_out), 7);
    check("rr_80_out",  int'(rr_out),  7);
    check("rr_80_vld",  int'(rr_vld),  1);
    // N=5 instance saw req=0 with ready=1: drops valid, index holds.
    check("rr5_zero_vld", int'(rr5_vld), 0);
    check("rr5_zero_out", int'(rr5_out), 3);

    // ---------------- reset mid-handshake ----------------
    drive(1'b1, 1'b1, 8'h80, 1'b0);
    step();
    check("rst_mid_lsb_out", int'(lsb_out), 0);
    check("rst_mid_lsb_vld", int'(lsb_vld), 0);
    check("rst_mid_msb_mul", int'(msb_mul), 0);
    check("rst_mid_rr_out",  int'(rr_out),  0);
    check("rst_mid_rr_vld",  int'(rr_vld),  0);

    // First grant after reset: round-robin starts from bit 0.
    drive(1'b0, 1'b1, 8'h81, 1'b1);
    step();
    check("rr_81_out",  int'(rr_out),  0);
    check("rr_81_mul",  int'(rr_mul),  1);
    check("msb_81_out", int'(msb_out), 7);
    check("rr5_01_out", int'(rr5_out), 0);
    check("rr5_01_vld", int'(rr5_vld), 1);

    // ---------------- round-robin rotation ----------------
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr_11_out%0d", i),  int'(rr_out),  rr8_seq[i]);
      check($sformatf("rr_11_vld%0d", i),  int'(rr_vld),  1);
      check($sformatf("rr5_11_out%0d", i), int'(rr5_out), rr5_seq[i]);
      check($sformatf("rr5_11_max%0d", i), int'(rr5_out <= 3'd4), 1);
    end
    check("lsb_11_out", int'(lsb_out), 0);
    check("msb_11_out", int'(msb_out), 4);

    // ---------------- backpressure ----------------
    drive(1'b0, 1'b1, 8'h04, 1'b1);
    step();
    check("bp_cap_out", int'(lsb_out), 2);
    check("bp_rr_out",  int'(rr_out),  2);   // ptr=4 -> 5,6,7,0,1,2
    drive(1'b0, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_out%0d", i), int'(lsb_out), 2);
      check($sformatf("bp_hold_vld%0d", i), int'(lsb_vld), 1);
      check($sformatf("bp_hold_rr%0d", i),  int'(rr_out),  2);
    end
    out_ready = 1'b1;
    step();
    check("bp_rel_lsb", int'(lsb_out), 6);
    check("bp_rel_msb", int'(msb_out), 6);
    check("bp_rel_rr",  int'(rr_out),  6);
    check("bp_rel_vld", int'(lsb_vld), 1);

    // ---------------- sel=0 / req=0 drain ----------------
    drive(1'b0, 1'b0, 8'hFF, 1'b1);
    step();
    check("sel0_vld", int'(lsb_vld), 0);
    check("sel0_out", int'(lsb_out), 6);

    drive(1'b0, 1'b1, 8'h02, 1'b1);
    step();
    check("req02_out", int'(lsb_out), 1);
    check("req02_vld", int'(lsb_vld), 1);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    step();
    check("req0_vld", int'(lsb_vld), 0);
    check("req0_out", int'(lsb_out), 1);
    check("req0_mul", int'(lsb_mul), 0);

    // Empty register captures even without out_ready.
    drive(1'b0, 1'b1, 8'h0C, 1'b0);
    step();
    check("empty_cap_out", int'(lsb_out), 2);
    check("empty_cap_vld", int'(lsb_vld), 1);
    check("empty_cap_mul", int'(lsb_mul), 1);
    check("empty_cap_msb", int'(msb_out), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_priority_encoder_rr

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 Parameter N, default 8, number of request inputs (N >= 2).
REQ-002 Parameter MODE, default 0: 0 = fixed LSB-first priority, 1 = fixed MSB-first priority, 2 = round-robin.
REQ-003 Localparam W = $clog2(N), index width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sel  input  1  enable; no capture when 0.
REQ-007 req_in  input  N  request vector, bit i = input i.
REQ-008 out_ready  input  1  downstream accepts result this cycle.
REQ-009 binary_out  output  W  registered index of the selected request.
REQ-010 out_valid  output  1  binary_out holds an unconsumed result.
REQ-011 multi  output  1  captured vector had more than one bit set.

Function
REQ-012 Capture condition (cap): sel=1, req_in != 0, and (out_valid=0 or out_ready=1).
REQ-013 On cap: binary_out <= selected index; out_valid <= 1; multi <= (popcount(req_in) > 1). Latency is 1 cycle from sampled req_in to out_valid.
REQ-014 MODE 0 selects the lowest set bit; MODE 1 selects the highest set bit.
REQ-015 MODE 2 selects the first set bit at or above ptr+1, wrapping modulo N; ptr holds the last granted index.
REQ-016 ptr updates to the granted index only on cap; it is unused in MODE 0/1.
REQ-017 out_valid=1, out_ready=0: binary_out, multi, out_valid and ptr hold; req_in changes are ignored.
REQ-018 out_valid=1, out_ready=1, no cap: out_valid <= 0; binary_out and multi hold their last values.
REQ-019 out_valid=1, out_ready=1, cap in the same cycle: new result is loaded back-to-back; out_valid stays 1 with no bubble.
REQ-020 req_in = 0 or sel=0: no cap and no error; behaviour follows REQ-017/018.
REQ-021 Single-bit req_in gives the same index in all modes; MODE 2 wrap: ptr=N-1 searches from bit 0.
REQ-022 No combinational path from req_in or sel to any output.

Reset
REQ-023 rst=1 at a clock edge: binary_out <= 0, out_valid <= 0, multi <= 0, ptr <= N-1, regardless of any other input.
REQ-024 Reset asserted mid-handshake discards any pending result; the first cap after reset deasserts behaves as from power-up.

Structure
REQ-025 Shared package enc_pkg holds the MODE encodings (MODE_LSB=0, MODE_MSB=1, MODE_RR=2).
REQ-026 One combinational sub-module rr_pick (parameters N, MODE; inputs req, ptr; outputs idx, found) performs the search; the top level holds all registers and the handshake.
REQ-027 Illegal MODE values are rejected at elaboration.

Verification
REQ-028 MODE 0, N=8, sel=1, req_in=8'h28, out_ready=1 -> next cycle binary_out=3, out_valid=1, multi=1.
REQ-029 MODE 1, N=8, req_in=8'h28 -> binary_out=5, multi=1; req_in=8'h80 -> binary_out=7, multi=0.
REQ-030 MODE 2, N=8, req_in=8'h11 held 4 cycles, out_ready=1 -> binary_out sequence 0,4,0,4 with out_valid continuously 1.
REQ-031 Backpressure: capture 8'h04 (idx 2), out_ready=0 for 3 cycles while req_in=8'h40 -> binary_out stays 2; out_ready=1 -> binary_out=6 next cycle.
REQ-032 sel=0 or req_in=0 with out_ready=1 -> out_valid drops after one handshake; rst=1 while out_valid=1 -> all outputs 0 next edge; MODE 2 first grant after reset with req_in=8'h81 -> 0.
REQ-033 N=5 (non-power-of-two), MODE 2, req_in=5'b10001 -> indices 0,4,0; W=3; binary_out never exceeds 4.
